// File: rtl/mux_arb_pkg.sv
// Shared encodings and helpers for the N-to-1 channel multiplexer/arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        MODE_SEL  = 2'd0,
        MODE_PRIO = 2'd1,
        MODE_RR   = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // Index following idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection for the channel mux: static select, fixed
// priority (lowest index wins) or round-robin starting at ptr.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic [1:0]      mode,
    input  logic [SELW-1:0] sel,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        case (mode_e'(mode))
            MODE_PRIO: begin
                // Descending scan so the lowest requesting index is written last.
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (req[SELW'(i)]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = SELW'(i);
                    end
                end
            end
            MODE_RR: begin
                for (int k = NCH - 1; k >= 0; k--) begin
                    cand = SELW'((int'(ptr) + k) % NCH);
                    if (req[cand]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = cand;
                    end
                end
            end
            default: begin
                // MODE_SEL and MODE_RSVD; an out-of-range sel never grants.
                if (int'(sel) < NCH) begin
                    if (req[sel]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = sel;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 stream multiplexer with valid/ready per channel, selectable
// arbitration and a one-entry registered output carrying the source index.
module mux_arb_nto1
    import mux_arb_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic             load;
    logic             xfer;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .mode      (mode),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Register can take a beat when empty or when its current beat drains this cycle.
    assign load = !out_valid_q || out_ready;
    assign xfer = load && gnt_valid && !rst;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                out_data_d = in_data[gnt_idx*WIDTH +: WIDTH];
                out_ch_d   = gnt_idx;
            end
        end
        if (xfer && (mode_e'(mode) == MODE_RR)) begin
            rr_ptr_d = SELW'(wrap_inc(int'(gnt_idx), NCH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares on each output handshake.
module tb_mux_arb_nto1;

    localparam int NCH   = 4;
    localparam int WIDTH = 32;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 rst;
    logic [1:0]           mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    logic [WIDTH-1:0]      ch_data [NCH];
    logic [WIDTH+SELW-1:0] sb_q [$];
    int checks;
    int failures;

    mux_arb_nto1 #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [7:0] tag, input int ch);
        return {8'hD0, tag, 8'h00, 8'(ch)};
    endfunction

    task automatic set_tags(input logic [7:0] tag);
        for (int i = 0; i < NCH; i++) ch_data[i] = exp_data(tag, i);
    endtask

    task automatic push(input logic [7:0] tag, input int ch);
        sb_q.push_back({exp_data(tag, ch), 2'(ch)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard.
    initial begin
        logic [WIDTH+SELW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got ch %0d data %h, expected no beat", out_ch, out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_data", 64'(out_data), 64'(e[WIDTH+SELW-1:SELW]));
                    chk("beat_ch", 64'(out_ch), 64'(e[SELW-1:0]));
                end
            end
        end
    end

    initial begin
        int exp_rr [6] = '{0, 1, 2, 3, 0, 1};
        checks   = 0;
        failures = 0;

        // Reset with all channels requesting
        rst = 1'b1; mode = 2'd0; sel = '0; in_valid = 4'hF; out_ready = 1'b1;
        set_tags(8'h10);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0; in_valid = 4'h0;
        step();

        // SEL mode, then sel pointing at an idle channel
        for (int i = 0; i < NCH; i++) ch_data[i] = '0;
        ch_data[2] = 32'hA5A5_0002;
        mode = 2'd0; sel = 2'd2; in_valid = 4'b0100;
        #1 chk("sel_in_ready", 64'(in_ready), 64'b0100);
        sb_q.push_back({32'hA5A5_0002, 2'd2});
        step();
        sel = 2'd3;
        #1 chk("sel_idle_in_ready", 64'(in_ready), 64'd0);
        step();
        #1 chk("sel_idle_out_valid", 64'(out_valid), 64'd0);

        // PRIO mode picks lowest requester
        mode = 2'd1; in_valid = 4'b1010; set_tags(8'h30);
        #1 chk("prio_in_ready", 64'(in_ready), 64'b0010);
        push(8'h30, 1);
        step();
        in_valid = 4'h0;
        #1 chk("prio_out_ch", 64'(out_ch), 64'd1);
        step();

        // Reserved mode behaves as SEL
        mode = 2'd3; sel = 2'd1; in_valid = 4'b0110; set_tags(8'h38);
        #1 chk("rsvd_in_ready", 64'(in_ready), 64'b0010);
        push(8'h38, 1);
        step();
        mode = 2'd0; sel = 2'd0;
        #1 chk("sel_no_req_in_ready", 64'(in_ready), 64'd0);
        step();
        #1 chk("sel_no_req_out_valid", 64'(out_valid), 64'd0);
        in_valid = 4'h0;

        // RR with all channels requesting; pointer must start at 0 and wrap
        for (int k = 0; k < 6; k++) begin
            mode = 2'd2; in_valid = 4'hF; out_ready = 1'b1; set_tags(8'(8'h40 + k));
            #1 chk("rr_in_ready", 64'(in_ready), 64'(1 << exp_rr[k]));
            push(8'(8'h40 + k), exp_rr[k]);
            step();
        end
        in_valid = 4'h0;
        step();

        // Backpressure: load channel 2, stall three cycles, then drain and fill together
        in_valid = 4'hF; out_ready = 1'b0; set_tags(8'h50);
        #1 chk("bp_first_in_ready", 64'(in_ready), 64'b0100);
        push(8'h50, 2);
        step();
        for (int j = 0; j < 3; j++) begin
            set_tags(8'(8'h51 + j));
            #1;
            chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
            chk("bp_stall_valid", 64'(out_valid), 64'd1);
            chk("bp_stall_data", 64'(out_data), 64'(exp_data(8'h50, 2)));
            chk("bp_stall_ch", 64'(out_ch), 64'd2);
            step();
        end
        set_tags(8'h60); out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 64'(in_ready), 64'b1000);
        push(8'h60, 3);
        step();
        in_valid = 4'h0;
        #1;
        chk("bp_no_bubble_valid", 64'(out_valid), 64'd1);
        chk("bp_no_bubble_ch", 64'(out_ch), 64'd3);
        step();
        step();
        chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset in the middle of a stall; RR must restart at channel 0
        mode = 2'd2; in_valid = 4'hF; out_ready = 1'b0; set_tags(8'h70);
        #1 chk("rst_stall_load_in_ready", 64'(in_ready), 64'b0001);
        push(8'h70, 0);
        step();
        #1 chk("rst_stall_held", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 64'(out_valid), 64'd0);
        chk("rst_async_out_data", 64'(out_data), 64'd0);
        chk("rst_async_in_ready", 64'(in_ready), 64'd0);
        sb_q.delete();
        step();
        rst = 1'b0; out_ready = 1'b1; set_tags(8'h80);
        #1 chk("rst_rr_restart", 64'(in_ready), 64'b0001);
        push(8'h80, 0);
        step();
        in_valid = 4'h0;
        step();
        step();
        chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
